// File: rtl/cpc_bus_pkg.sv
// Shared definitions for the CPC expansion-bus initiator: command opcodes,
// FSM state codes, ROM region decoding and small decode helpers.
package cpc_bus_pkg;

  // Host command opcodes
  localparam logic [1:0] OP_MEMRD = 2'd0;
  localparam logic [1:0] OP_MEMWR = 2'd1;
  localparam logic [1:0] OP_IORD  = 2'd2;
  localparam logic [1:0] OP_IOWR  = 2'd3;

  // Bus-cycle FSM state codes
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_T1   = 3'd1;
  localparam state_t ST_T2   = 3'd2;
  localparam state_t ST_TWA  = 3'd3;
  localparam state_t ST_TW   = 3'd4;
  localparam state_t ST_T3   = 3'd5;

  // A15:14 patterns of the upper and lower ROM windows
  localparam logic [1:0] UPPER_ROM_A = 2'b11;
  localparam logic [1:0] LOWER_ROM_A = 2'b00;

  // The ROM-select port decodes on A13 low during an I/O write
  localparam logic [15:0] ROMSEL_A13_MASK = 16'h2000;

  function automatic logic op_is_io(input logic [1:0] op);
    return (op == OP_IORD) || (op == OP_IOWR);
  endfunction

  function automatic logic op_is_write(input logic [1:0] op);
    return (op == OP_MEMWR) || (op == OP_IOWR);
  endfunction

  // ROMEN_B is only ever pulled low for memory reads inside an enabled ROM window
  function automatic logic rom_read_hit(input logic [1:0] op, input logic [15:0] addr,
                                        input logic upper_en, input logic lower_en);
    return (op == OP_MEMRD) &&
           (((addr[15:14] == UPPER_ROM_A) && upper_en) ||
            ((addr[15:14] == LOWER_ROM_A) && lower_en));
  endfunction

  // True when a command addresses the ROM-select port
  function automatic logic is_romsel_write(input logic [1:0] op, input logic [15:0] addr);
    return (op == OP_IOWR) && ((addr & ROMSEL_A13_MASK) == 16'h0000);
  endfunction

endpackage

// File: rtl/cpc_tstate_timer.sv
// T-state prescaler: divides the system clock by CLK_PER_T and flags the
// last clock of each T-state. Held at zero while the master is idle so the
// first T-state after an accept always has full length.
module cpc_tstate_timer #(
  parameter int CLK_PER_T = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic t_end
);

  localparam int CW = (CLK_PER_T > 1) ? $clog2(CLK_PER_T) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_T - 1);

  logic [CW-1:0] cnt;

  assign t_end = run && (cnt == LAST);

  // Count clocks within the current T-state, wrapping on the last one
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/cpc_bus_master.sv
// Z80-style bus initiator for the CPC expansion connector. Runs one
// memory or I/O bus cycle per accepted host command and reports the
// sampled data, ROMDIS and wait-timeout status with a one-cycle pulse.
module cpc_bus_master
  import cpc_bus_pkg::*;
#(
  parameter int CLK_PER_T = 1,
  parameter int MAX_WAIT  = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  input  logic        upper_rom_en,
  input  logic        lower_rom_en,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_romdis,
  output logic        rsp_timeout,
  output logic [15:0] A,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in,
  output logic        MREQ_B,
  output logic        IOREQ_B,
  output logic        RD_B,
  output logic        WR_B,
  output logic        M1_B,
  output logic        RFSH_B,
  output logic        ROMEN_B,
  input  logic        READY,
  input  logic        ROMDIS
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

  state_t         state;
  logic [1:0]     op_q;
  logic [15:0]    addr_q;
  logic [7:0]     wdata_q;
  logic           rom_hit_q;
  logic           timeout_q;
  logic [WCW-1:0] wait_cnt;
  logic [WCW-1:0] wait_nxt;
  logic           t_end;
  logic           busy;
  logic           strobe;
  logic           is_io;
  logic           is_wr;

  assign busy     = (state != ST_IDLE);
  assign strobe   = (state == ST_T2) || (state == ST_TWA) || (state == ST_TW) || (state == ST_T3);
  assign is_io    = op_is_io(op_q);
  assign is_wr    = op_is_write(op_q);
  assign wait_nxt = wait_cnt + WCW'(1);

  cpc_tstate_timer #(
    .CLK_PER_T(CLK_PER_T)
  ) u_timer (
    .clk   (CLK),
    .reset (RESET),
    .run   (busy),
    .t_end (t_end)
  );

  // Bus-cycle sequencer: latch the command, walk T1/T2/waits/T3, emit the response
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_IDLE;
      op_q        <= OP_MEMRD;
      addr_q      <= 16'h0000;
      wdata_q     <= 8'h00;
      rom_hit_q   <= 1'b0;
      timeout_q   <= 1'b0;
      wait_cnt    <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'h00;
      rsp_romdis  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            rom_hit_q <= rom_read_hit(cmd_op, cmd_addr, upper_rom_en, lower_rom_en);
            timeout_q <= 1'b0;
            wait_cnt  <= '0;
            state     <= ST_T1;
          end
        end
        ST_T1: begin
          if (t_end) state <= ST_T2;
        end
        ST_T2: begin
          if (t_end) begin
            if (is_io)       state <= ST_TWA;
            else if (!READY) state <= ST_TW;
            else             state <= ST_T3;
          end
        end
        ST_TWA: begin
          if (t_end) state <= READY ? ST_T3 : ST_TW;
        end
        ST_TW: begin
          if (t_end) begin
            wait_cnt <= wait_nxt;
            if (READY) begin
              state <= ST_T3;
            end else if (wait_nxt == WAIT_LIMIT) begin
              timeout_q <= 1'b1;
              state     <= ST_T3;
            end
          end
        end
        ST_T3: begin
          if (t_end) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= is_wr ? 8'h00 : D_in;
            rsp_romdis  <= is_wr ? 1'b0 : ROMDIS;
            rsp_timeout <= timeout_q;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bus pins are decoded directly from the state and the latched command
  always_comb begin
    cmd_ready = !busy;
    A         = busy ? addr_q : 16'h0000;
    D_oe      = busy && is_wr;
    D_out     = (busy && is_wr) ? wdata_q : 8'h00;
    MREQ_B    = !(strobe && !is_io);
    IOREQ_B   = !(strobe && is_io);
    RD_B      = !(strobe && !is_wr);
    WR_B      = !(strobe && is_wr);
    ROMEN_B   = !(strobe && rom_hit_q);
    M1_B      = 1'b1;
    RFSH_B    = 1'b1;
  end

endmodule

// File: tb/tb_cpc_bus_master.sv
// Self-checking bench for cpc_bus_master. Two instances: one with one
// clock per T-state and one with four; a select bit routes commands and
// observation to one of them. Table vectors cover the main bus cycles,
// hand sequences cover reset in the middle of a cycle.
module tb_cpc_bus_master;
  import cpc_bus_pkg::*;

  typedef struct {
    int op, addr, wdata, din, romdis_in, upper, lower, sel4, ready_lo, ready_hi;
    int lat, rdata, romdis, timeout, mreq, iorq, rd, wr, romen, doe;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        cmd_valid;
  logic        sel4;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        upper_rom_en, lower_rom_en;
  logic [7:0]  D_in;
  logic        READY, ROMDIS;

  logic        cmd_valid_1, cmd_valid_4;
  logic        cmd_ready_1, rsp_valid_1, rsp_romdis_1, rsp_timeout_1, D_oe_1;
  logic        cmd_ready_4, rsp_valid_4, rsp_romdis_4, rsp_timeout_4, D_oe_4;
  logic [7:0]  rsp_rdata_1, D_out_1, rsp_rdata_4, D_out_4;
  logic [15:0] A_1, A_4;
  logic [6:0]  strb_1, strb_4;

  logic        o_ready, o_rsp_valid, o_romdis, o_timeout, o_doe;
  logic [7:0]  o_rdata, o_dout;
  logic [15:0] o_a;
  logic [6:0]  o_strb;

  int n_checks = 0;
  int n_fail   = 0;

  int got_lat, got_rdata, got_romdis, got_timeout;
  int c_mreq, c_iorq, c_rd, c_wr, c_romen, c_doe, a_bad, dout_bad, m1_bad, idle_ok;

  vec_t vecs[12];

  assign cmd_valid_1 = cmd_valid && !sel4;
  assign cmd_valid_4 = cmd_valid && sel4;

  assign o_ready     = sel4 ? cmd_ready_4   : cmd_ready_1;
  assign o_rsp_valid = sel4 ? rsp_valid_4   : rsp_valid_1;
  assign o_romdis    = sel4 ? rsp_romdis_4  : rsp_romdis_1;
  assign o_timeout   = sel4 ? rsp_timeout_4 : rsp_timeout_1;
  assign o_doe       = sel4 ? D_oe_4        : D_oe_1;
  assign o_rdata     = sel4 ? rsp_rdata_4   : rsp_rdata_1;
  assign o_dout      = sel4 ? D_out_4       : D_out_1;
  assign o_a         = sel4 ? A_4           : A_1;
  assign o_strb      = sel4 ? strb_4        : strb_1;

  cpc_bus_master #(.CLK_PER_T(1), .MAX_WAIT(16)) dut (
    .CLK(CLK), .RESET(RESET), .cmd_valid(cmd_valid_1), .cmd_ready(cmd_ready_1),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .upper_rom_en(upper_rom_en), .lower_rom_en(lower_rom_en),
    .rsp_valid(rsp_valid_1), .rsp_rdata(rsp_rdata_1), .rsp_romdis(rsp_romdis_1),
    .rsp_timeout(rsp_timeout_1), .A(A_1), .D_out(D_out_1), .D_oe(D_oe_1), .D_in(D_in),
    .MREQ_B(strb_1[6]), .IOREQ_B(strb_1[5]), .RD_B(strb_1[4]), .WR_B(strb_1[3]),
    .M1_B(strb_1[2]), .RFSH_B(strb_1[1]), .ROMEN_B(strb_1[0]),
    .READY(READY), .ROMDIS(ROMDIS)
  );

  cpc_bus_master #(.CLK_PER_T(4), .MAX_WAIT(16)) dut4 (
    .CLK(CLK), .RESET(RESET), .cmd_valid(cmd_valid_4), .cmd_ready(cmd_ready_4),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .upper_rom_en(upper_rom_en), .lower_rom_en(lower_rom_en),
    .rsp_valid(rsp_valid_4), .rsp_rdata(rsp_rdata_4), .rsp_romdis(rsp_romdis_4),
    .rsp_timeout(rsp_timeout_4), .A(A_4), .D_out(D_out_4), .D_oe(D_oe_4), .D_in(D_in),
    .MREQ_B(strb_4[6]), .IOREQ_B(strb_4[5]), .RD_B(strb_4[4]), .WR_B(strb_4[3]),
    .M1_B(strb_4[2]), .RFSH_B(strb_4[1]), .ROMEN_B(strb_4[0]),
    .READY(READY), .ROMDIS(ROMDIS)
  );

  // Free-running 100 MHz system clock
  always #5 CLK = ~CLK;

  // Hard stop in case something upstream wedges the bench entirely
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Run one command starting from a negedge with the selected DUT idle;
  // returns at the negedge of the response cycle so the next call is back-to-back
  task automatic applyStimulus(input vec_t v);
    sel4         = v.sel4[0];
    cmd_op       = 2'(v.op);
    cmd_addr     = 16'(v.addr);
    cmd_wdata    = 8'(v.wdata);
    upper_rom_en = v.upper[0];
    lower_rom_en = v.lower[0];
    D_in         = 8'(v.din);
    ROMDIS       = v.romdis_in[0];
    READY        = 1'b1;
    cmd_valid    = 1'b1;
    got_lat = -1; got_rdata = -1; got_romdis = -1; got_timeout = -1; idle_ok = 0;
    c_mreq = 0; c_iorq = 0; c_rd = 0; c_wr = 0; c_romen = 0; c_doe = 0;
    a_bad = 0; dout_bad = 0; m1_bad = 0;
    @(posedge CLK);
    for (int k = 1; k <= 200; k++) begin
      @(negedge CLK);
      cmd_valid = 1'b0;
      READY = (k >= v.ready_lo && k <= v.ready_hi) ? 1'b0 : 1'b1;
      if (!o_strb[6]) c_mreq++;
      if (!o_strb[5]) c_iorq++;
      if (!o_strb[4]) c_rd++;
      if (!o_strb[3]) c_wr++;
      if (!o_strb[0]) c_romen++;
      if (o_doe) c_doe++;
      if (!o_strb[2] || !o_strb[1]) m1_bad++;
      if (!o_ready && o_a != 16'(v.addr)) a_bad++;
      if (o_doe && o_dout != 8'(v.wdata)) dout_bad++;
      if (o_rsp_valid) begin
        got_lat     = k;
        got_rdata   = int'(o_rdata);
        got_romdis  = int'(o_romdis);
        got_timeout = int'(o_timeout);
        idle_ok     = (o_ready && o_strb == 7'h7F && !o_doe) ? 1 : 0;
        break;
      end
    end
    READY = 1'b1;
  endtask

  task automatic check_vector(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    checkOutput({p, ".latency"}, got_lat, v.lat);
    checkOutput({p, ".rdata"}, got_rdata, v.rdata);
    checkOutput({p, ".romdis"}, got_romdis, v.romdis);
    checkOutput({p, ".timeout"}, got_timeout, v.timeout);
    checkOutput({p, ".mreq_cycles"}, c_mreq, v.mreq);
    checkOutput({p, ".iorq_cycles"}, c_iorq, v.iorq);
    checkOutput({p, ".rd_cycles"}, c_rd, v.rd);
    checkOutput({p, ".wr_cycles"}, c_wr, v.wr);
    checkOutput({p, ".romen_cycles"}, c_romen, v.romen);
    checkOutput({p, ".doe_cycles"}, c_doe, v.doe);
    checkOutput({p, ".addr_errs"}, a_bad, 0);
    checkOutput({p, ".dout_errs"}, dout_bad, 0);
    checkOutput({p, ".m1_rfsh_low"}, m1_bad, 0);
    checkOutput({p, ".idle_at_rsp"}, idle_ok, 1);
  endtask

  // Main sequence: reset checks, vector table, mid-cycle reset, post-reset read
  initial begin
    int rsp_seen;
    //            op addr     wd    din   rdi up lo s4 rlo rhi  lat rdata rdis to mreq iorq rd wr romen doe
    vecs[0]  = '{3, 'hDF00, 'h05, 'hEE, 1, 0, 0, 0, 0, 0,   5, 'h00, 0, 0,  0,  3,  0,  3,  0, 4};
    vecs[1]  = '{0, 'hC000, 'h00, 'hA5, 1, 1, 0, 0, 0, 0,   4, 'hA5, 1, 0,  2,  0,  2,  0,  2, 0};
    vecs[2]  = '{0, 'h8000, 'h00, 'h3C, 0, 1, 1, 0, 0, 0,   4, 'h3C, 0, 0,  2,  0,  2,  0,  0, 0};
    vecs[3]  = '{0, 'h0000, 'h00, 'h11, 1, 1, 0, 0, 0, 0,   4, 'h11, 1, 0,  2,  0,  2,  0,  0, 0};
    vecs[4]  = '{1, 'hC000, 'h77, 'hFF, 1, 1, 1, 0, 0, 0,   4, 'h00, 0, 0,  2,  0,  0,  2,  0, 3};
    vecs[5]  = '{0, 'h0100, 'h00, 'h5A, 0, 0, 1, 0, 0, 0,   4, 'h5A, 0, 0,  2,  0,  2,  0,  2, 0};
    vecs[6]  = '{2, 'h7F10, 'h00, 'hC3, 1, 1, 1, 0, 0, 0,   5, 'hC3, 1, 0,  0,  3,  3,  0,  0, 0};
    vecs[7]  = '{0, 'hFFFF, 'h00, 'h81, 0, 0, 1, 0, 0, 0,   4, 'h81, 0, 0,  2,  0,  2,  0,  0, 0};
    vecs[8]  = '{0, 'h0010, 'h00, 'h96, 1, 0, 1, 0, 2, 4,   7, 'h96, 1, 0,  5,  0,  5,  0,  5, 0};
    vecs[9]  = '{0, 'hC000, 'h00, 'h69, 0, 1, 0, 1, 5, 16, 25, 'h69, 0, 0, 20,  0, 20,  0, 20, 0};
    vecs[10] = '{2, 'hFB7E, 'h00, 'h42, 0, 0, 0, 0, 1, 999, 21, 'h42, 0, 1, 0, 19, 19,  0,  0, 0};
    vecs[11] = '{0, 'hC123, 'h00, 'h5E, 0, 1, 0, 0, 0, 0,   4, 'h5E, 0, 0,  2,  0,  2,  0,  2, 0};

    RESET = 1'b1; cmd_valid = 1'b0; sel4 = 1'b0; cmd_op = OP_MEMRD;
    cmd_addr = 16'h0000; cmd_wdata = 8'h00; upper_rom_en = 1'b0; lower_rom_en = 1'b0;
    D_in = 8'h00; READY = 1'b1; ROMDIS = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    $display("[TB] checking reset state");
    checkOutput("reset.cmd_ready", cmd_ready_1, 1);
    checkOutput("reset.rsp", {rsp_valid_1, rsp_romdis_1, rsp_timeout_1, rsp_rdata_1}, 0);
    checkOutput("reset.A", A_1, 0);
    checkOutput("reset.D_out", D_out_1, 0);
    checkOutput("reset.D_oe", D_oe_1, 0);
    checkOutput("reset.strobes", strb_1, 'h7F);
    checkOutput("reset.dut4_idle", {cmd_ready_4, strb_4, D_oe_4}, 'hFF << 1);
    RESET = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 11; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i]);
      check_vector(i, vecs[i]);
    end

    $display("[TB] reset during T2 of a memory write");
    sel4 = 1'b0; cmd_op = OP_MEMWR; cmd_addr = 16'h4000; cmd_wdata = 8'h99;
    cmd_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    cmd_valid = 1'b0;
    @(negedge CLK);
    checkOutput("rst.in_t2_wr_b", strb_1[3], 0);
    RESET = 1'b1;
    @(negedge CLK);
    checkOutput("rst.strobes", strb_1, 'h7F);
    checkOutput("rst.D_oe", D_oe_1, 0);
    checkOutput("rst.cmd_ready", cmd_ready_1, 1);
    checkOutput("rst.rsp", {rsp_valid_1, rsp_romdis_1, rsp_timeout_1, rsp_rdata_1}, 0);
    RESET = 1'b0;
    rsp_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (rsp_valid_1) rsp_seen++;
    end
    checkOutput("rst.no_rsp", rsp_seen, 0);

    $display("[TB] read after reset");
    applyStimulus(vecs[11]);
    check_vector(11, vecs[11]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
